spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 154 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that writes one of five 8-bit PWM configuration registers per 16-bit frame.
// All SPI pins are synchronized into the clk domain; the frame is evaluated when chip select rises.
module spi_reg_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        RECV
    } state_t;

    localparam logic [1:0] SETTLE_CYC = 2'(SYNC_STAGES);

    // Bit SYNC_STAGES-1 is the synchronized value, bit SYNC_STAGES the history flop.
    logic [SYNC_STAGES:0] sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_STAGES:0] copi_pipe_q, copi_pipe_d;
    logic [SYNC_STAGES:0] ncs_pipe_q, ncs_pipe_d;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [1:0]  settle_q, settle_d;
    logic [7:0]  out_lo_q, out_lo_d;
    logic [7:0]  out_hi_q, out_hi_d;
    logic [7:0]  pwm_lo_q, pwm_lo_d;
    logic [7:0]  pwm_hi_q, pwm_hi_d;
    logic [7:0]  duty_q, duty_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        frame_err_q, frame_err_d;

    logic sclk_rise;
    logic ncs_s;
    logic ncs_fall;
    logic ncs_rise;
    logic copi_bit;

    assign sclk_rise = sclk_pipe_q[SYNC_STAGES-1] & ~sclk_pipe_q[SYNC_STAGES];
    assign ncs_s     = ncs_pipe_q[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_pipe_q[SYNC_STAGES-1] & ncs_pipe_q[SYNC_STAGES];
    assign ncs_rise  = ncs_pipe_q[SYNC_STAGES-1] & ~ncs_pipe_q[SYNC_STAGES];
    // copi from the history stage: the value seen one clk before sclk was seen to rise.
    assign copi_bit  = copi_pipe_q[SYNC_STAGES];

    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], sclk};
        copi_pipe_d = {copi_pipe_q[SYNC_STAGES-1:0], copi};
        ncs_pipe_d  = {ncs_pipe_q[SYNC_STAGES-1:0], ncs};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        settle_d    = settle_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        pwm_lo_d    = pwm_lo_q;
        pwm_hi_d    = pwm_hi_q;
        duty_d      = duty_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_HI: begin
                // Reset preloads the synchronizers; only trust ncs once real pin samples reach the output.
                if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
                if (settle_q >= SETTLE_CYC && ncs_s) state_d = IDLE;
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == 5'd16) begin
                        if (shift_q[15] && shift_q[14:8] <= 7'd4) begin
                            wr_strobe_d = 1'b1;
                            case (shift_q[10:8])
                                3'd0:    out_lo_d = shift_q[7:0];
                                3'd1:    out_hi_d = shift_q[7:0];
                                3'd2:    pwm_lo_d = shift_q[7:0];
                                3'd3:    pwm_hi_d = shift_q[7:0];
                                default: duty_d   = shift_q[7:0];
                            endcase
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], copi_bit};
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_q <= '0;
            copi_pipe_q <= '0;
            ncs_pipe_q  <= '1;
            state_q     <= WAIT_HI;
            cnt_q       <= '0;
            shift_q     <= '0;
            settle_q    <= '0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            pwm_lo_q    <= '0;
            pwm_hi_q    <= '0;
            duty_q      <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_pipe_q <= sclk_pipe_d;
            copi_pipe_q <= copi_pipe_d;
            ncs_pipe_q  <= ncs_pipe_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            settle_q    <= settle_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            pwm_lo_q    <= pwm_lo_d;
            pwm_hi_q    <= pwm_hi_d;
            duty_q      <= duty_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed and randomized frame checks for spi_reg_ctrl: register contents, pulses and latency.
module tb_spi_reg_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe, frame_err;
    logic [39:0] snap;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int n_err = 0;

    spi_reg_ctrl #(.SYNC_STAGES(S)) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign snap = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

    always @(negedge clk) begin
        if (wr_strobe) n_wr++;
        if (frame_err) n_err++;
        if (wr_strobe && frame_err) begin
            total++;
            bad++;
            $display("FAIL strobe_and_err_together wr_strobe=%0b frame_err=%0b required=not both", wr_strobe, frame_err);
        end
    end

    typedef struct {
        logic [31:0] v;
        int          n;
        int          half;
        logic [39:0] snap;
        int          wr;
        int          err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            clk_n(half);
            sclk = 1'b1;
            clk_n(half);
            sclk = 1'b0;
        end
    endtask

    // Returns the number of negedges after ncs rises at which the first pulse was seen (0 = none).
    task automatic run_frame(input logic [31:0] v, input int n, input int half, output int lat);
        ncs = 1'b0;
        clk_n(half);
        shift_bits(v, n, half);
        clk_n(half);
        ncs = 1'b1;
        lat = 0;
        for (int k = 1; k <= S + 4; k++) begin
            @(negedge clk);
            if (lat == 0 && (wr_strobe || frame_err)) lat = k;
        end
        clk_n(2);
    endtask

    task automatic check_frame(input string tag, input logic [39:0] exp_snap, input int wr0, input int err0,
                               input int exp_wr, input int exp_err, input int lat);
        check({tag, "_regs"}, 64'(snap), 64'(exp_snap));
        check({tag, "_wr_count"}, 64'(n_wr - wr0), 64'(exp_wr));
        check({tag, "_err_count"}, 64'(n_err - err0), 64'(exp_err));
        if (exp_wr != 0 || exp_err != 0)
            check({tag, "_latency_in_bound"}, 64'(lat >= 1 && lat <= S + 2), 64'd1);
        else
            check({tag, "_no_pulse"}, 64'(lat), 64'd0);
    endtask

    initial begin
        int lat, wr0, err0;
        logic [39:0] exp_snap;

        tbl[0]  = '{32'h0000_80A5, 16, 2, 40'h00_00_00_00_A5, 1, 0};
        tbl[1]  = '{32'h0000_8480, 16, 3, 40'h80_00_00_00_A5, 1, 0};
        tbl[2]  = '{32'h0000_820F, 16, 8, 40'h80_00_0F_00_A5, 1, 0};
        tbl[3]  = '{32'h0000_40BB, 15, 2, 40'h80_00_0F_00_A5, 0, 1};
        tbl[4]  = '{32'h0001_02EF, 17, 2, 40'h80_00_0F_00_A5, 0, 1};
        tbl[5]  = '{32'h0000_03FF, 16, 2, 40'h80_00_0F_00_A5, 0, 0};
        tbl[6]  = '{32'h0000_90FF, 16, 5, 40'h80_00_0F_00_A5, 0, 0};
        tbl[7]  = '{32'h0000_8533, 16, 2, 40'h80_00_0F_00_A5, 0, 0};
        tbl[8]  = '{32'h0000_815A, 16, 2, 40'h80_00_0F_5A_A5, 1, 0};
        tbl[9]  = '{32'h0000_83C3, 16, 4, 40'h80_C3_0F_5A_A5, 1, 0};
        tbl[10] = '{32'h0000_0000, 0,  2, 40'h80_C3_0F_5A_A5, 0, 1};
        tbl[11] = '{32'h0000_FF11, 16, 2, 40'h80_C3_0F_5A_A5, 0, 0};

        clk_n(4);
        rst = 1'b0;
        clk_n(1);
        check("reset_regs", 64'(snap), 64'd0);
        check("reset_wr_strobe", 64'(wr_strobe), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        clk_n(S + 3);

        for (int i = 0; i < 12; i++) begin
            wr0 = n_wr;
            err0 = n_err;
            run_frame(tbl[i].v, tbl[i].n, tbl[i].half, lat);
            check_frame($sformatf("vec%0d", i), tbl[i].snap, wr0, err0, tbl[i].wr, tbl[i].err, lat);
        end

        // Reset in the middle of a write of 0x3C to address 0x00, ncs kept low across release.
        wr0 = n_wr;
        err0 = n_err;
        ncs = 1'b0;
        clk_n(2);
        shift_bits(32'h80, 8, 2);
        rst = 1'b1;
        clk_n(3);
        rst = 1'b0;
        clk_n(2);
        shift_bits(32'h3C, 8, 2);
        clk_n(2);
        ncs = 1'b1;
        clk_n(S + 6);
        check("midreset_regs", 64'(snap), 64'd0);
        check("midreset_wr_count", 64'(n_wr - wr0), 64'd0);
        check("midreset_err_count", 64'(n_err - err0), 64'd0);
        wr0 = n_wr;
        err0 = n_err;
        run_frame(32'h8011, 16, 2, lat);
        check_frame("after_midreset", 40'h00_00_00_00_11, wr0, err0, 1, 0, lat);

        // sclk activity with ncs high, then two frames separated by only 4 clk of ncs high.
        wr0 = n_wr;
        err0 = n_err;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            clk_n(2);
            sclk = 1'b0;
            clk_n(2);
        end
        ncs = 1'b0;
        clk_n(2);
        shift_bits(32'h8480, 16, 2);
        clk_n(2);
        ncs = 1'b1;
        clk_n(4);
        ncs = 1'b0;
        clk_n(2);
        shift_bits(32'h820F, 16, 2);
        clk_n(2);
        ncs = 1'b1;
        clk_n(S + 6);
        check("b2b_regs", 64'(snap), 64'h80_00_0F_00_11);
        check("b2b_wr_count", 64'(n_wr - wr0), 64'd2);
        check("b2b_err_count", 64'(n_err - err0), 64'd0);

        // Random frames across sclk:clk ratios 4..16 against a behavioural model.
        exp_snap = 40'h80_00_0F_00_11;
        for (int i = 0; i < 30; i++) begin
            int ratio, sel, n, ew, ee;
            logic [15:0] word;
            logic [31:0] v;
            ratio = $urandom_range(16, 4);
            sel = $urandom_range(9, 0);
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            word[15] = ($urandom_range(3, 0) != 0);
            word[14:8] = 7'($urandom_range(7, 0));
            word[7:0] = 8'($urandom);
            v = (n == 15) ? 32'(word[15:1]) : (n == 17) ? {15'd0, word, 1'b1} : {16'd0, word};
            ew = 0;
            ee = 0;
            if (n != 16) begin
                ee = 1;
            end else if (word[15] && word[14:8] <= 7'd4) begin
                ew = 1;
                exp_snap[8 * int'(word[10:8]) +: 8] = word[7:0];
            end
            wr0 = n_wr;
            err0 = n_err;
            run_frame(v, n, ratio / 2, lat);
            check_frame($sformatf("rand%0d_r%0d", i, ratio), exp_snap, wr0, err0, ew, ee, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
